// File: rtl/dm_cache.sv
// Direct-mapped write-back, write-allocate data cache; hits complete in the request cycle.
// Misses hold miss high through an optional dirty-victim writeback and a line refill; memory paces via mem_gnt.
module dm_cache #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [31:0]                          addr,
  input  logic                                 rd_req,
  output logic [31:0]                          rd_data,
  input  logic                                 wr_req,
  input  logic [31:0]                          wr_data,
  output logic                                 miss,
  output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0] mem_addr,
  output logic                                 mem_rd_req,
  output logic                                 mem_wr_req,
  input  logic                                 mem_gnt,
  input  logic [31:0]                          mem_rd_line [1<<LINE_ADDR_LEN],
  output logic [31:0]                          mem_wr_line [1<<LINE_ADDR_LEN]
);

  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int SET_SIZE  = 1 << SET_ADDR_LEN;
  localparam int ADDR_TOP  = TAG_ADDR_LEN + SET_ADDR_LEN + LINE_ADDR_LEN + 2;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] SWAP_OUT   = 2'd1;
  localparam logic [1:0] SWAP_IN    = 2'd2;
  localparam logic [1:0] SWAP_IN_OK = 2'd3;

  logic [1:0]              state;
  logic [SET_SIZE-1:0]     valid;
  logic [SET_SIZE-1:0]     dirty;
  logic [TAG_ADDR_LEN-1:0] tag_array  [SET_SIZE];
  logic [31:0]             data_array [SET_SIZE][LINE_SIZE];

  logic [LINE_ADDR_LEN-1:0] word_sel;
  logic [SET_ADDR_LEN-1:0]  set_sel;
  logic [TAG_ADDR_LEN-1:0]  tag_sel;
  logic                     unused_addr;

  assign word_sel    = addr[LINE_ADDR_LEN+1:2];
  assign set_sel     = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign tag_sel     = addr[ADDR_TOP-1:LINE_ADDR_LEN+SET_ADDR_LEN+2];
  assign unused_addr = ^{addr[31:ADDR_TOP], addr[1:0]};

  logic req;
  logic hit;
  logic idle_hit;
  logic victim_dirty;
  logic store_word;
  logic fill_line;
  logic load_victim;

  assign req          = rd_req | wr_req;
  assign hit          = valid[set_sel] && (tag_array[set_sel] == tag_sel);
  assign idle_hit     = (state == IDLE) && hit;
  assign victim_dirty = valid[set_sel] && dirty[set_sel];

  // Array writes are gated by rst so a reset during SWAP_IN_OK drops the incoming line.
  assign store_word  = rst && idle_hit && wr_req && !rd_req;
  assign fill_line   = rst && (state == SWAP_IN_OK);
  assign load_victim = rst && (state == IDLE) && req && !hit && victim_dirty;

  assign miss       = req && !idle_hit;
  assign rd_data    = (idle_hit && rd_req) ? data_array[set_sel][word_sel] : 32'h0;
  assign mem_rd_req = (state == SWAP_IN);
  assign mem_wr_req = (state == SWAP_OUT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (!rd_req) dirty[set_sel] <= 1'b1;
            end else if (victim_dirty) begin
              state    <= SWAP_OUT;
              mem_addr <= {tag_array[set_sel], set_sel};
            end else begin
              state    <= SWAP_IN;
              mem_addr <= {tag_sel, set_sel};
            end
          end
        end
        SWAP_OUT: begin
          if (mem_gnt) begin
            state          <= SWAP_IN;
            mem_addr       <= {tag_sel, set_sel};
            dirty[set_sel] <= 1'b0;
          end
        end
        SWAP_IN: begin
          if (mem_gnt) state <= SWAP_IN_OK;
        end
        SWAP_IN_OK: begin
          valid[set_sel] <= 1'b1;
          dirty[set_sel] <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store_word) data_array[set_sel][word_sel] <= wr_data;
    if (fill_line) begin
      data_array[set_sel] <= mem_rd_line;
      tag_array[set_sel]  <= tag_sel;
    end
    if (load_victim) mem_wr_line <= data_array[set_sel];
  end

endmodule

// File: tb/tb_dm_cache.sv
// Bench for dm_cache: coherent word-level reference plus line residency model, and a
// line memory that grants every request after a fixed delay.
module tb_dm_cache;

  localparam int LINE_SIZE = 8;
  localparam int SET_SIZE  = 8;
  localparam int MEM_LINES = 256;
  localparam int GNT_DELAY = 10;

  logic        clk = 1'b1;
  logic        rst;
  logic [31:0] addr;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        miss;
  logic [7:0]  mem_addr;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic        mem_gnt;
  logic [31:0] mem_rd_line [LINE_SIZE];
  logic [31:0] mem_wr_line [LINE_SIZE];

  dm_cache #(
    .LINE_ADDR_LEN(3),
    .SET_ADDR_LEN (3),
    .TAG_ADDR_LEN (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .miss       (miss),
    .mem_addr   (mem_addr),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_gnt    (mem_gnt),
    .mem_rd_line(mem_rd_line),
    .mem_wr_line(mem_wr_line)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Main memory contents, CPU-visible value of every word, and which line each set holds.
  logic [31:0] mem_store [MEM_LINES][LINE_SIZE];
  logic [31:0] ref_word  [MEM_LINES*LINE_SIZE];
  logic        res_valid [SET_SIZE];
  logic        res_dirty [SET_SIZE];
  logic [4:0]  res_tag   [SET_SIZE];
  bit          mem_inited;
  int          cnt;
  logic        xfer_wr;
  logic [7:0]  xfer_line;
  logic        wb_seen;
  int          rd_cycles;
  int          wr_cycles;

  always @(negedge clk) begin : cmp
    logic [10:0] wa;
    logic [2:0]  s;
    logic [4:0]  t;
    logic        creq;
    logic        resident;
    if (!mem_inited) begin
      mem_inited = 1'b1;
      for (int l = 0; l < MEM_LINES; l++)
        for (int k = 0; k < LINE_SIZE; k++) begin
          // Line 2 reads back as 0x100+k; other lines carry a distinguishing upper half.
          mem_store[l][k]             = 32'(32'h100 + k + ((l ^ 2) << 16));
          ref_word[l*LINE_SIZE + k]   = mem_store[l][k];
        end
      for (int k = 0; k < LINE_SIZE; k++) mem_rd_line[k] = 32'h0;
      rd_cycles = 0;
      wr_cycles = 0;
    end
    wa = addr[12:2];
    s  = addr[7:5];
    t  = addr[12:8];
    if (!rst) begin
      for (int i = 0; i < SET_SIZE; i++) begin
        res_valid[i] = 1'b0;
        res_dirty[i] = 1'b0;
      end
      mem_gnt = 1'b0;
      cnt     = 0;
      wb_seen = 1'b0;
    end else begin
      creq     = rd_req | wr_req;
      resident = res_valid[s] && (res_tag[s] == t);
      check("miss", miss, creq && !resident);
      check("rd_data", rd_data, (rd_req && resident) ? ref_word[wa] : 32'h0);
      if (!creq || resident) begin
        check("mem_rd_req quiet", mem_rd_req, 1'b0);
        check("mem_wr_req quiet", mem_wr_req, 1'b0);
      end
      if (mem_wr_req) begin
        wr_cycles++;
        check("writeback only for dirty victim", res_dirty[s], 1'b1);
        check("writeback mem_addr", mem_addr, {res_tag[s], s});
        for (int k = 0; k < LINE_SIZE; k++)
          check("writeback line word", mem_wr_line[k], ref_word[{res_tag[s], s, 3'(k)}]);
      end
      if (mem_rd_req) begin
        rd_cycles++;
        check("refill mem_addr", mem_addr, {t, s});
        check("single mem request", mem_wr_req, 1'b0);
      end
      if (wr_req && !rd_req && resident) begin
        ref_word[wa] = wr_data;
        res_dirty[s] = 1'b1;
      end
      if (mem_gnt) begin
        mem_gnt = 1'b0;
        cnt     = 0;
        if (xfer_wr) begin
          for (int k = 0; k < LINE_SIZE; k++) mem_store[xfer_line][k] = mem_wr_line[k];
          wb_seen = 1'b1;
        end else begin
          for (int k = 0; k < LINE_SIZE; k++) mem_rd_line[k] = mem_store[xfer_line][k];
          check("writeback precedes refill", wb_seen, res_valid[s] && res_dirty[s]);
          wb_seen      = 1'b0;
          res_valid[s] = 1'b1;
          res_tag[s]   = t;
          res_dirty[s] = 1'b0;
        end
      end else if (mem_rd_req || mem_wr_req) begin
        cnt++;
        if (cnt == GNT_DELAY) begin
          mem_gnt   = 1'b1;
          xfer_wr   = mem_wr_req;
          xfer_line = mem_addr;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    rd_req  = r;
    wr_req  = w;
    addr    = a;
    wr_data = d;
  endtask

  task automatic wait_hit(input string name, output int n);
    n = 0;
    while (miss && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(name, miss, 1'b0);
  endtask

  task automatic wait_rd_req(input string name);
    int n = 0;
    while (!mem_rd_req && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(name, mem_rd_req, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rd0;
    int wr0;
    rst = 1'b0; addr = 32'h0; rd_req = 1'b0; wr_req = 1'b0; wr_data = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("reset miss", miss, 1'b0);
    check("reset rd_data", rd_data, 32'h0);
    check("reset mem_rd_req", mem_rd_req, 1'b0);
    check("reset mem_wr_req", mem_wr_req, 1'b0);
    check("reset mem_addr", mem_addr, 8'h00);

    // Cold read miss: IDLE, 10 cycles of SWAP_IN, SWAP_IN_OK, then the hit.
    rd0 = rd_cycles; wr0 = wr_cycles;
    drive(1'b1, 1'b0, 32'h44, 32'h0); #1;
    check("cold miss asserted", miss, 1'b1);
    wait_hit("cold miss completes", n);
    check("cold miss cycles", n, 12);
    check("cold rd_data", rd_data, 32'h101);
    check("cold swap_in cycles", rd_cycles - rd0, GNT_DELAY);
    check("cold no writeback", wr_cycles - wr0, 0);

    drive(1'b1, 1'b0, 32'h5C, 32'h0); #1;
    check("hit miss", miss, 1'b0);
    check("hit rd_data", rd_data, 32'h107);
    check("hit no mem req", mem_rd_req | mem_wr_req, 1'b0);

    drive(1'b0, 1'b1, 32'h44, 32'hDEADBEEF); #1;
    check("write hit miss", miss, 1'b0);
    drive(1'b1, 1'b0, 32'h44, 32'h0); #1;
    check("read after write", rd_data, 32'hDEADBEEF);

    // Conflict miss on a dirty victim: writeback of line 0x02, then refill of 0x0A.
    rd0 = rd_cycles; wr0 = wr_cycles;
    drive(1'b1, 1'b0, 32'h144, 32'h0); #1;
    check("conflict miss asserted", miss, 1'b1);
    @(posedge clk); #2;
    check("swap_out mem_wr_req", mem_wr_req, 1'b1);
    check("swap_out mem_addr", mem_addr, 8'h02);
    check("victim word 1", mem_wr_line[1], 32'hDEADBEEF);
    wait_rd_req("swap_in after writeback");
    check("swap_in mem_addr", mem_addr, 8'h0A);
    wait_hit("conflict miss completes", n);
    check("conflict rd_data", rd_data, 32'h00080101);
    check("writeback cycles", wr_cycles - wr0, GNT_DELAY);
    check("memory holds written word", mem_store[2][1], 32'hDEADBEEF);

    // Clean valid victim: straight to refill.
    rd0 = rd_cycles; wr0 = wr_cycles;
    drive(1'b1, 1'b0, 32'h44, 32'h0); #1;
    check("clean victim miss asserted", miss, 1'b1);
    wait_hit("clean victim miss completes", n);
    check("clean victim miss cycles", n, 12);
    check("clean victim no writeback", wr_cycles - wr0, 0);
    check("refilled written word", rd_data, 32'hDEADBEEF);

    drive(1'b1, 1'b1, 32'h48, 32'h12345678); #1;
    check("both high miss", miss, 1'b0);
    check("both high rd_data", rd_data, 32'h102);
    drive(1'b1, 1'b0, 32'h48, 32'h0); #1;
    check("both high word unchanged", rd_data, 32'h102);

    // Reset during SWAP_IN.
    drive(1'b1, 1'b0, 32'h244, 32'h0);
    wait_rd_req("swap_in before reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rd_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("reset drops mem_rd_req", mem_rd_req, 1'b0);
    check("reset miss idle", miss, 1'b0);
    drive(1'b1, 1'b0, 32'h44, 32'h0); #1;
    check("valid cleared by reset", miss, 1'b1);
    wait_hit("post-reset miss completes", n);
    check("post-reset rd_data", rd_data, 32'hDEADBEEF);

    // Write miss allocates the line, then the held store lands as a hit.
    drive(1'b0, 1'b1, 32'h64, 32'hCAFEF00D); #1;
    check("write miss asserted", miss, 1'b1);
    wait_hit("write miss completes", n);
    drive(1'b1, 1'b0, 32'h64, 32'h0); #1;
    check("write-allocate read", rd_data, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 32'h60, 32'h0); #1;
    check("write-allocate neighbour", rd_data, 32'h00010100);

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
